// File: rtl/misr_ora.sv
// LBIST output response analyzer: Galois MISR compaction of CUT responses with a
// registered golden-signature verdict. Optional X-masking input under MISR_X_MASK_EN.
module misr_ora #(
  parameter int unsigned       BITS   = 3,
  parameter logic [BITS-1:0]   POLY   = 3'b011,
  parameter logic [BITS-1:0]   GOLDEN = 3'b011,
  parameter int unsigned       CW     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] resp,
  input  logic            resp_valid,
  input  logic            end_in,
`ifdef MISR_X_MASK_EN
  input  logic [BITS-1:0] resp_mask,
`endif
  output logic [BITS-1:0] signature,
  output logic [CW-1:0]   count,
  output logic            busy,
  output logic            done,
  output logic            pass
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPACT = 2'd1,
    S_CHECK   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_clear;
  logic            w_update;
  logic [BITS-1:0] w_resp_eff;
  logic [BITS-1:0] w_sig_next;
  logic [BITS-1:0] r_sig;
  logic [CW-1:0]   r_count;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;

`ifdef MISR_X_MASK_EN
  // Unknown bits are forced to 0 so they cannot corrupt the signature.
  assign w_resp_eff = resp & ~resp_mask;
`else
  assign w_resp_eff = resp;
`endif

  assign w_sig_next = {r_sig[BITS-2:0], 1'b0} ^ (r_sig[BITS-1] ? POLY : '0) ^ w_resp_eff;

  // Next-state and datapath control
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_update     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_COMPACT;
          w_clear      = 1'b1;
        end
      end
      S_COMPACT: begin
        w_update = resp_valid;
        if (end_in) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        w_state_next = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          w_state_next = S_COMPACT;
          w_clear      = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, signature, counter and verdict registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sig   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == S_COMPACT) || (w_state_next == S_CHECK);
      r_done  <= (w_state_next == S_DONE);
      if (w_clear) begin
        r_sig   <= '0;
        r_count <= '0;
        r_pass  <= 1'b0;
      end else begin
        if (w_update) begin
          r_sig <= w_sig_next;
          if (!(&r_count)) begin
            r_count <= r_count + CW'(1);
          end
        end
        if (r_state == S_CHECK) begin
          r_pass <= (r_sig == GOLDEN);
        end
      end
    end
  end

  assign signature = r_sig;
  assign count     = r_count;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;

endmodule

// File: tb/tb_misr_ora.sv
// Randomized scoreboard bench for misr_ora; the reference reduces the signature
// polynomial modulo the feedback polynomial. Define MISR_X_MASK_EN to cover masking.
module tb_misr_ora;

  localparam int unsigned BITS   = 3;
  localparam int unsigned CW     = 8;
  localparam logic [2:0]  POLY   = 3'b011;
  localparam logic [2:0]  GOLDEN = 3'b011;
  localparam int unsigned SMASK  = (1 << BITS) - 1;
  localparam int unsigned CMAX   = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [BITS-1:0] resp = '0;
  logic            resp_valid = 1'b0;
  logic            end_in = 1'b0;
`ifdef MISR_X_MASK_EN
  logic [BITS-1:0] resp_mask = '0;
`endif
  logic [BITS-1:0] signature;
  logic [CW-1:0]   count;
  logic            busy;
  logic            done;
  logic            pass;

  misr_ora #(.BITS(BITS), .POLY(POLY), .GOLDEN(GOLDEN), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .resp       (resp),
    .resp_valid (resp_valid),
    .end_in     (end_in),
`ifdef MISR_X_MASK_EN
    .resp_mask  (resp_mask),
`endif
    .signature  (signature),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .pass       (pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned sig;
    int unsigned cnt;
    bit          pass;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   prev_done = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Multiply by x in GF(2)[x] and reduce modulo x^BITS + POLY, then add the response.
  function automatic int unsigned model_step(input int unsigned s, input int unsigned r);
    int unsigned t;
    t = s * 2;
    if (t >= (1 << BITS)) t = t ^ ((1 << BITS) | int'(POLY));
    return (t ^ r) & SMASK;
  endfunction

  function automatic int unsigned eff(input int unsigned r, input int unsigned m);
`ifdef MISR_X_MASK_EN
    return r & ~m & SMASK;
`else
    return r & SMASK + 0 * m;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Verdict monitor: on each rising done, compare against the oldest expectation.
  always @(negedge clk) begin
    if (rst && done && !prev_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: got done=1 expected no verdict (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_signature", signature, e.sig);
        chk("sb_count", count, e.cnt);
        chk("sb_pass", pass, e.pass);
      end
    end
    prev_done = done;
  end

  task automatic do_run(input int unsigned rs[$], input int unsigned ms[$],
                        input bit gaps, input bit end_no_valid);
    int unsigned s = 0;
    int unsigned c = 0;
    int unsigned n = rs.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("sig_cleared", signature, 0);
    chk("count_cleared", count, 0);
    chk("done_cleared", done, 0);
    for (int i = 0; i < int'(n); i++) begin
      bit last;
      if (gaps && $urandom_range(0, 3) == 0) begin
        resp_valid = 1'b0;
        end_in     = 1'b0;
        resp       = BITS'($urandom);
        start      = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        chk("gap_sig_hold", signature, s);
        chk("gap_count_hold", count, c);
      end
      last       = (i == int'(n) - 1) && !end_no_valid;
      resp       = BITS'(rs[i]);
`ifdef MISR_X_MASK_EN
      resp_mask  = BITS'(ms[i]);
`endif
      resp_valid = 1'b1;
      end_in     = last;
      s = model_step(s, eff(rs[i], ms[i]));
      if (c < CMAX) c++;
      if (last) sb.push_back('{sig: s, cnt: c, pass: (s == int'(GOLDEN))});
      tick();
      chk("sig_step", signature, s);
    end
    if (end_no_valid) begin
      resp_valid = 1'b0;
      end_in     = 1'b1;
      resp       = BITS'($urandom);
      sb.push_back('{sig: s, cnt: c, pass: (s == int'(GOLDEN))});
      tick();
    end
    resp_valid = 1'b0;
    end_in     = 1'b0;
`ifdef MISR_X_MASK_EN
    resp_mask  = '0;
`endif
    chk("check_busy", busy, 1);
    chk("check_done_low", done, 0);
    start = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    chk("verdict_busy_low", busy, 0);
    chk("verdict_done", done, 1);
    repeat (2) begin
      resp_valid = 1'b1;
      resp       = BITS'($urandom);
      tick();
    end
    resp_valid = 1'b0;
    chk("done_hold_sig", signature, s);
    chk("done_hold_count", count, c);
    chk("done_hold_level", done, 1);
    chk("done_hold_pass", pass, (s == int'(GOLDEN)) ? 1 : 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rs[$];
    int unsigned ms[$];

    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("rst_signature", signature, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);

    // Golden match: 001, 000, 011 -> pass
    rs = '{1, 2, 3}; ms = '{0, 0, 0};
    do_run(rs, ms, 1'b0, 1'b0);
    // Feedback path: 100 then 011 -> pass
    rs = '{4, 0}; ms = '{0, 0};
    do_run(rs, ms, 1'b0, 1'b0);
    // Mismatch: 001, 000, 100 -> fail
    rs = '{1, 2, 4}; ms = '{0, 0, 0};
    do_run(rs, ms, 1'b0, 1'b0);
    // end_in with resp_valid=0 closes the run without absorbing
    rs = '{1, 2, 3}; ms = '{0, 0, 0};
    do_run(rs, ms, 1'b1, 1'b1);

`ifdef MISR_X_MASK_EN
    rs = '{1, 2, 3}; ms = '{4, 4, 4};
    do_run(rs, ms, 1'b0, 1'b0);
    rs = '{7}; ms = '{4};
    do_run(rs, ms, 1'b0, 1'b0);
`endif

    // Abort mid-run; simultaneous start loses to reset
    start = 1'b1; tick(); start = 1'b0;
    resp_valid = 1'b1; resp = 3'd5; tick();
    resp = 3'd6; tick();
    rst = 1'b0; start = 1'b1; resp = 3'd7; tick();
    chk("abort_signature", signature, 0);
    chk("abort_count", count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    rst = 1'b1; start = 1'b0; resp = 3'd3; tick();
    chk("idle_ignores_resp_sig", signature, 0);
    chk("idle_ignores_resp_busy", busy, 0);
    resp_valid = 1'b0;
    rs = '{1, 2, 3}; ms = '{0, 0, 0};
    do_run(rs, ms, 1'b0, 1'b0);

    // Counter saturation
    rs = '{}; ms = '{};
    for (int i = 0; i < 300; i++) begin
      rs.push_back($urandom_range(0, SMASK));
      ms.push_back($urandom_range(0, SMASK));
    end
    do_run(rs, ms, 1'b0, 1'b0);

    // Random runs
    for (int r = 0; r < 30; r++) begin
      int unsigned len;
      bit          env;
      len = $urandom_range(1, 12);
      env = 1'($urandom_range(0, 1));
      rs = '{}; ms = '{};
      for (int i = 0; i < int'(len); i++) begin
        rs.push_back($urandom_range(0, SMASK));
        ms.push_back($urandom_range(0, SMASK));
      end
      do_run(rs, ms, 1'b1, env);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/misr_ora.md
# misr_ora

Output response analyzer for the LBIST chain. It sits directly downstream of the random pattern generator and the circuit under test. It compacts each CUT response word into a multiple-input signature register (MISR), stops when the generator raises its end-of-sequence flag, and compares the final signature against a golden value. A single registered pass/fail verdict goes to the BIST controller.

## Interface
Parameters:
- BITS, 3, width of the response word and of the MISR.
- POLY, 3'b011, Galois feedback taps applied when the MISR MSB is 1 (x^3+x+1 for BITS=3).
- GOLDEN, 3'b011, expected final signature.
- CW, 8, width of the response counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous and active-low.
- start  input  1  one-cycle pulse that begins a compaction run.
- resp  input  BITS  CUT response word.
- resp_valid  input  1  resp is valid this cycle.
- end_in  input  1  end-of-sequence flag from the pattern generator; high means this is the last response.
- signature  output  BITS  current MISR contents.
- count  output  CW  number of responses absorbed, saturating at 2^CW-1.
- busy  output  1  high in COMPACT and CHECK.
- done  output  1  verdict valid; high in DONE.
- pass  output  1  signature == GOLDEN; meaningful only while done=1.

## Operation
- States:
  - IDLE: waiting for start.
  - COMPACT: absorbing responses.
  - CHECK: one cycle, compares signature against GOLDEN.
  - DONE: holds the verdict.
- MISR update, taken when state==COMPACT and resp_valid=1: sig_next = ({sig[BITS-2:0],1'b0} ^ (sig[BITS-1] ? POLY : 0)) ^ resp_eff.
  - resp_eff = resp, or the masked resp when MISR_X_MASK_EN is defined.
- Count: increments by 1 on every update and saturates at all-ones. It does not wrap.
- Transitions:
  - IDLE→COMPACT on start. Signature and count clear to 0 on that edge.
  - COMPACT→CHECK on resp_valid=1 and end_in=1. The response in that cycle is absorbed.
  - end_in=1 with resp_valid=0 also moves COMPACT→CHECK, with no update.
  - CHECK→DONE unconditionally. pass is registered as (signature==GOLDEN).
  - DONE→COMPACT on start. Signature, count and pass clear and a new run begins.
  - DONE otherwise holds signature, count, pass and done.
- start is ignored in COMPACT and CHECK.
- resp_valid is ignored outside COMPACT.
- Reset mid-run: the run is aborted. The block returns to IDLE with every output cleared and no verdict.

## Timing
- Reset values:
  - signature = 0, count = 0, busy = 0, done = 0, pass = 0.
  - state = IDLE.
- start sampled at edge T: busy=1 from T. The first response can be absorbed at edge T+1.
- Each valid response changes signature on the same edge it is sampled.
- end_in sampled at edge E:
  - state=CHECK after E.
  - done=1 and pass valid after edge E+1, so the verdict latency is 1 cycle after the last response.
  - busy falls at E+1.
- done is a level, not a pulse. It stays high until start or reset.
- Simultaneous start and reset: reset wins.

## Configuration
- MISR_X_MASK_EN defined:
  - Adds input port resp_mask [BITS-1:0].
  - resp_eff = resp & ~resp_mask, so masked (unknown-X) bits are forced to 0 before compaction.
  - The mask is sampled together with resp.
- Not defined: the port is absent and resp_eff = resp.

## Test plan
- Reset: hold rst=0 for 2 cycles, then release → signature=0, count=0, busy=0, done=0, pass=0, block idle.
- Golden match: start, then resp 1, 2, 3 on consecutive cycles, with end_in=1 on the 3 → signature steps 001, 000, 011; count=3; done=1 one cycle later; pass=1.
- Mismatch: same stimulus built with GOLDEN=3'b101 → signature=011, done=1, pass=0.
- Feedback path: start, then resp 4 followed by resp 0 with end_in → signature 100 then 011; pass=1. This proves the POLY feedback is applied when the MSB is 1.
- Protocol and abort:
  - start pulsed during COMPACT → ignored.
  - resp_valid=0 cycles → no change to signature or count.
  - rst=0 after two responses → IDLE and all outputs 0.
  - A fresh run after that reproduces 011.
- With MISR_X_MASK_EN defined: resp 1, 2, 3 with resp_mask=3'b100 on every word → same signature 011. Then resp 7 with mask 3'b100 as a single word → signature=011.
